// File: rtl/median_pkg.sv
// Shared types and constants for the serial-median initiator.
package median_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StSend,
    StWait,
    StDone
  } state_e;

  localparam int unsigned NPIX        = 9;
  localparam int unsigned TMO_DEFAULT = 63;
  localparam int unsigned MED_LATENCY = 45;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned TMO_W       = 6;

endpackage

// File: rtl/median_driver_if.sv
// Window-in / median-out handshakes plus the serial link to one MEDIAN unit.
interface median_driver_if
  import median_pkg::*;
#(
  parameter int unsigned width = 8
);

  logic [NPIX*width-1:0] WIN;
  logic                  WIN_VALID;
  logic                  WIN_READY;
  logic                  M_nRST;
  logic [width-1:0]      M_DI;
  logic                  M_DSI;
  logic [width-1:0]      M_DO;
  logic                  M_DSO;
  logic [width-1:0]      RES;
  logic                  RES_VALID;
  logic                  RES_READY;
  logic                  TIMEOUT;

  modport master (
    input  WIN, WIN_VALID, M_DO, M_DSO, RES_READY,
    output WIN_READY, M_nRST, M_DI, M_DSI, RES, RES_VALID, TIMEOUT
  );

  modport slave (
    output WIN, WIN_VALID, M_DO, M_DSO, RES_READY,
    input  WIN_READY, M_nRST, M_DI, M_DSI, RES, RES_VALID, TIMEOUT
  );

endinterface

// File: rtl/median_driver_pix_shift.sv
// Loadable shift register holding one window; head is the next pixel to send.
module pix_shift #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   shift,
  input  logic [depth*width-1:0] data,
  output logic [width-1:0]       head
);

  logic [width-1:0] stage_q [depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(depth); i++) stage_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < int'(depth); i++) stage_q[i] <= data[i*width +: width];
    end else if (shift) begin
      for (int i = 0; i < int'(depth) - 1; i++) stage_q[i] <= stage_q[i+1];
      stage_q[depth-1] <= '0;
    end
  end

  assign head = stage_q[0];

endmodule

// File: rtl/median_driver.sv
// Streams a 3x3 window into a serial MEDIAN unit and returns its median.
module median_driver
  import median_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned TMO   = TMO_DEFAULT
) (
  input logic             CLK,
  input logic             RST,
  median_driver_if.master bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(NPIX - 1);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tcnt_q, tcnt_d;
  logic [width-1:0]   di_q, di_d;
  logic               dsi_q, dsi_d;
  logic               nrst_q, nrst_d;
  logic [width-1:0]   res_q, res_d;
  logic               timeout_q, timeout_d;
  logic               load, shift;
  logic [width-1:0]   head;

  pix_shift #(
    .width(width),
    .depth(NPIX)
  ) u_shift (
    .clk  (CLK),
    .rst  (RST),
    .load (load),
    .shift(shift),
    .data (bus.WIN),
    .head (head)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      di_q      <= '0;
      dsi_q     <= 1'b0;
      nrst_q    <= 1'b0;
      res_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      di_q      <= di_d;
      dsi_q     <= dsi_d;
      nrst_q    <= nrst_d;
      res_q     <= res_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are registered from the next state, so each state's values
  // appear during the cycle that state is occupied.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    di_d      = di_q;
    dsi_d     = dsi_q;
    nrst_d    = nrst_q;
    res_d     = res_q;
    timeout_d = timeout_q;
    load      = 1'b0;
    shift     = 1'b0;

    unique case (state_q)
      StIdle: begin
        nrst_d = 1'b1;
        if (bus.WIN_VALID) begin
          load    = 1'b1;
          nrst_d  = 1'b0;
          dsi_d   = 1'b0;
          state_d = StClr;
        end
      end
      StClr: begin
        nrst_d  = 1'b1;
        dsi_d   = 1'b1;
        di_d    = head;
        shift   = 1'b1;
        cnt_d   = '0;
        tcnt_d  = '0;
        state_d = StSend;
      end
      StSend: begin
        if (cnt_q == CntLast) begin
          dsi_d   = 1'b0;
          tcnt_d  = '0;
          state_d = StWait;
        end else begin
          di_d  = head;
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        tcnt_d = tcnt_q + 1'b1;
        // DSO wins over the timeout on the same edge.
        if (bus.M_DSO) begin
          res_d   = bus.M_DO;
          state_d = StDone;
        end else if (tcnt_q == TmoLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDone: begin
        if (bus.RES_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.WIN_READY = (state_q == StIdle);
  assign bus.RES_VALID = (state_q == StDone);
  assign bus.M_nRST    = nrst_q;
  assign bus.M_DI      = di_q;
  assign bus.M_DSI     = dsi_q;
  assign bus.RES       = res_q;
  assign bus.TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_median_driver.sv
// Bench for median_driver with a behavioural MEDIAN unit and a result scoreboard.
module tb_median_driver;
  import median_pkg::*;

  typedef struct {
    logic [7:0] res;
    int         acc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic stub = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t       sb_q[$];
  logic [7:0] pix_q[$];

  median_driver_if #(.width(8)) bus ();

  median_driver #(
    .width(8),
    .TMO  (63)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural MEDIAN unit: captures strobed pixels, DSO sticky after 45 counting edges.
  logic [7:0] mbuf [9];
  int         mcnt = 0;
  int         mpix = 0;
  logic       mdso = 1'b0;
  logic [7:0] mdo = 8'h00;

  function automatic logic [7:0] med9(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  always @(posedge CLK) begin
    if (!bus.M_nRST) begin
      mcnt <= 0; mpix <= 0; mdso <= 1'b0; mdo <= 8'h00;
    end else begin
      mcnt <= mcnt + 1;
      if (bus.M_DSI && mpix < 9) begin
        mbuf[mpix] <= bus.M_DI;
        mpix <= mpix + 1;
      end
      if (mcnt + 1 == int'(MED_LATENCY) && !mdso) begin
        mdso <= 1'b1;
        mdo  <= med9(mbuf);
      end
    end
  end

  assign bus.M_DO  = mdo;
  assign bus.M_DSO = mdso & ~stub;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: results, pixel stream and the M_nRST pulse.
  bit rv_seen = 0;
  int dsi_run = 0;
  int nrst_low = 0;
  always @(negedge CLK) begin
    if (RST) begin
      rv_seen = 0; dsi_run = 0; nrst_low = 0;
    end else begin
      if (bus.RES_VALID && !rv_seen) begin
        rv_seen = 1;
        if (sb_q.size() == 0) begin
          check("unexpected_res", 32'(bus.RES_VALID), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("res_value", 32'(bus.RES), 32'(e.res));
          check("res_latency", 32'(cyc - e.acc), 32'd47);
        end
      end
      if (!bus.RES_VALID) rv_seen = 0;
      if (bus.M_DSI) begin
        dsi_run++;
        if (pix_q.size() == 0) check("unexpected_dsi", 32'(bus.M_DSI), 32'd0);
        else check("pixel", 32'(bus.M_DI), 32'(pix_q.pop_front()));
      end else if (dsi_run != 0) begin
        check("dsi_len", 32'(dsi_run), 32'd9);
        dsi_run = 0;
      end
      if (!bus.M_nRST) begin
        nrst_low++;
      end else if (nrst_low != 0) begin
        check("nrst_pulse_len", 32'(nrst_low), 32'd1);
        check("send_after_clr", 32'(bus.M_DSI), 32'd1);
        nrst_low = 0;
      end
    end
  end

  function automatic logic [71:0] pack(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic send_window(input logic [71:0] w, input bit exp_res, input logic [7:0] res,
                             output int acc);
    int n;
    @(negedge CLK);
    bus.WIN = w;
    bus.WIN_VALID = 1'b1;
    n = 0;
    while (!bus.WIN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    acc = cyc + 1;
    if (!bus.WIN_READY) begin
      check("accept_timeout", 32'(bus.WIN_READY), 32'd1);
      bus.WIN_VALID = 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) pix_q.push_back(w[i*8 +: 8]);
      if (exp_res) sb_q.push_back('{res: res, acc: acc});
      @(posedge CLK);
      #1 bus.WIN_VALID = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.WIN_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("idle_reached", 32'(bus.WIN_READY), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_win_ready"}, 32'(bus.WIN_READY), 32'd1);
    check({tag, "_m_nrst"},    32'(bus.M_nRST),    32'd0);
    check({tag, "_m_di"},      32'(bus.M_DI),      32'd0);
    check({tag, "_m_dsi"},     32'(bus.M_DSI),     32'd0);
    check({tag, "_res"},       32'(bus.RES),       32'd0);
    check({tag, "_res_valid"}, 32'(bus.RES_VALID), 32'd0);
    check({tag, "_timeout"},   32'(bus.TIMEOUT),   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int rel;
    int n;
    bus.WIN = '0;
    bus.WIN_VALID = 1'b0;
    bus.RES_READY = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    #1 RST = 1'b0;

    send_window(pack(9, 1, 8, 2, 7, 3, 6, 4, 5), 1, 8'd5, acc);
    wait_idle();

    send_window({9{8'h10}}, 1, 8'h10, acc);
    send_window(pack(8'hFF, 0, 8'hFF, 0, 8'hFF, 0, 8'hFF, 0, 8'hFF), 1, 8'hFF, acc);
    wait_idle();

    // Consumer stall with a second window waiting.
    bus.RES_READY = 1'b0;
    send_window(pack(20, 10, 30, 50, 40, 60, 90, 80, 70), 1, 8'd50, acc);
    n = 0;
    while (!bus.RES_VALID && n < 200) begin
      @(negedge CLK);
      n++;
    end
    bus.WIN = pack(7, 7, 7, 1, 1, 1, 9, 9, 9);
    bus.WIN_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("stall_res_valid", 32'(bus.RES_VALID), 32'd1);
      check("stall_res", 32'(bus.RES), 32'd50);
      check("stall_win_ready", 32'(bus.WIN_READY), 32'd0);
    end
    bus.RES_READY = 1'b1;
    rel = cyc;
    send_window(pack(7, 7, 7, 1, 1, 1, 9, 9, 9), 1, 8'd7, acc);
    check("accept_after_release", 32'(acc - rel), 32'd2);
    wait_idle();

    // Timeout with DSO stubbed low.
    stub = 1'b1;
    send_window(pack(9, 1, 8, 2, 7, 3, 6, 4, 5), 0, 8'd0, acc);
    n = 0;
    while (!bus.TIMEOUT && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("timeout_set", 32'(bus.TIMEOUT), 32'd1);
    check("timeout_cycle", 32'(cyc - acc), 32'd73);
    check("timeout_idle", 32'(bus.WIN_READY), 32'd1);
    stub = 1'b0;
    send_window({9{8'h42}}, 1, 8'h42, acc);
    wait_idle();
    check("timeout_sticky", 32'(bus.TIMEOUT), 32'd1);

    // Reset in the middle of SEND, at pixel count 4.
    send_window(pack(11, 22, 33, 44, 55, 66, 77, 88, 99), 1, 8'd55, acc);
    repeat (5) @(posedge CLK);
    #3;
    check("midsend_dsi", 32'(bus.M_DSI), 32'd1);
    check("midsend_di", 32'(bus.M_DI), 32'd55);
    RST = 1'b1;
    pix_q.delete();
    sb_q.delete();
    #1 check_reset_vals("midrst");
    @(negedge CLK);
    #1 RST = 1'b0;
    send_window(pack(2, 9, 4, 7, 6, 5, 8, 3, 1), 1, 8'd5, acc);
    wait_idle();

    // Extremes across the full 72-bit window.
    send_window({9{8'hFF}}, 1, 8'hFF, acc);
    wait_idle();
    send_window(pack(0, 0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1, 8'h00, acc);
    wait_idle();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
